// File: rtl/cordic_pkg.sv
// Shared constants, types and helpers for the unrolled CORDIC cosine pipeline.
// All fixed-point values are signed Q2.30 (1.0 = 0x4000_0000).
package cordic_pkg;

  localparam int CORDIC_ITERATIONS = 16;
  localparam int CORDIC_LATENCY    = 5;
  localparam int FRAC_BITS         = 30;
  localparam int STAGE_ITERS       = 4;

  // Float exponent that maps the 24-bit mantissa straight onto Q2.30 without shifting.
  localparam int F2Q_BIAS    = 127 + 23 - FRAC_BITS;
  localparam int F2Q_MIN_EXP = F2Q_BIAS - 24;
  localparam int Q2F_BIAS    = 127 - FRAC_BITS;

  localparam logic [31:0] K_Q30   = 32'h26DD_3B6A;
  localparam logic [31:0] NAN_F32 = 32'h7FC0_0000;

  // atan(2^-i) in Q2.30, truncated toward zero.
  localparam logic [31:0] ATAN_Q30 [CORDIC_ITERATIONS] = '{
    32'h3243_F6A8, 32'h1DAC_6705, 32'h0FAD_BAFC, 32'h07F5_6EA6,
    32'h03FE_AB76, 32'h01FF_D55B, 32'h00FF_FAAA, 32'h007F_FF55,
    32'h003F_FFEA, 32'h001F_FFFD, 32'h000F_FFFF, 32'h0007_FFFF,
    32'h0003_FFFF, 32'h0001_FFFF, 32'h0000_FFFF, 32'h0000_7FFF
  };

  typedef struct packed {
    logic               flag;
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic signed [31:0] z;
  } cordic_vec_t;

  function automatic logic [4:0] lead_one(input logic [31:0] v);
    logic [4:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) p = 5'(i);
    end
    return p;
  endfunction

endpackage

// File: rtl/cordic_stage4.sv
// One registered pipeline stage performing four consecutive CORDIC micro-rotations.
// STAGE_IDX (1..4) selects iterations 4*(STAGE_IDX-1) .. 4*STAGE_IDX-1.
module cordic_stage4
  import cordic_pkg::*;
#(
  parameter int STAGE_IDX = 1
) (
  input  logic        clock,
  input  logic        aclr,
  input  logic        clk_en,
  input  cordic_vec_t vec_i,
  output cordic_vec_t vec_o
);

  localparam int BASE = STAGE_ITERS * (STAGE_IDX - 1);

  logic signed [31:0] x_w [STAGE_ITERS+1];
  logic signed [31:0] y_w [STAGE_ITERS+1];
  logic signed [31:0] z_w [STAGE_ITERS+1];
  cordic_vec_t        vec_d;
  cordic_vec_t        vec_q;

  assign x_w[0] = vec_i.x;
  assign y_w[0] = vec_i.y;
  assign z_w[0] = vec_i.z;

  for (genvar k = 0; k < STAGE_ITERS; k++) begin : g_iter
    localparam int                 SH     = BASE + k;
    localparam logic signed [31:0] ATAN_I = ATAN_Q30[SH];
    logic rot_neg;

    // Rotate toward z = 0: a negative residual angle reverses the direction.
    assign rot_neg    = z_w[k][31];
    assign x_w[k+1]   = rot_neg ? x_w[k] + (y_w[k] >>> SH) : x_w[k] - (y_w[k] >>> SH);
    assign y_w[k+1]   = rot_neg ? y_w[k] - (x_w[k] >>> SH) : y_w[k] + (x_w[k] >>> SH);
    assign z_w[k+1]   = rot_neg ? z_w[k] + ATAN_I : z_w[k] - ATAN_I;
  end

  assign vec_d = '{
    flag: vec_i.flag,
    x:    x_w[STAGE_ITERS],
    y:    y_w[STAGE_ITERS],
    z:    z_w[STAGE_ITERS]
  };

  always_ff @(posedge clock) begin
    if (aclr)        vec_q <= '0;
    else if (clk_en) vec_q <= vec_d;
  end

  assign vec_o = vec_q;

endmodule

// File: rtl/cordic_unroll4_var.sv
// Fully pipelined single-precision cos(): float -> Q2.30, four 4-iteration CORDIC
// stages, Q2.30 -> float. A start issued on an enabled edge yields done LATENCY enabled edges later.
module cordic_unroll4_var #(
  parameter int ITERATIONS = 16,
  parameter int LATENCY    = 5
) (
  input  logic        clock,
  input  logic        aclr,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic [31:0] result,
  output logic        done
);

  import cordic_pkg::*;

  localparam int NUM_STAGES = ITERATIONS / STAGE_ITERS;

  logic [LATENCY-1:0] start_sr_q;
  logic [LATENCY-1:0] start_sr_d;
  cordic_vec_t        s0_q;
  cordic_vec_t        s0_d;
  cordic_vec_t        pipe [NUM_STAGES+1];

  logic [7:0]         in_exp;
  logic [23:0]        in_mant;
  logic [31:0]        angle;

  logic signed [31:0] out_x;
  logic [4:0]         out_lead;
  logic               unused_bits;

  // |dataa| to Q2.30; the sign is dropped because cos is even.
  // NOTE: every always_comb output is given a default first so no path can infer a latch.
  always_comb begin
    in_exp  = dataa[30:23];
    in_mant = {1'b1, dataa[22:0]};
    angle   = '0;
    if (in_exp[7] || in_exp <= 8'(F2Q_MIN_EXP)) begin
      angle = '0;
    end else if (in_exp >= 8'(F2Q_BIAS)) begin
      angle = {8'd0, in_mant} << (in_exp - 8'(F2Q_BIAS));
    end else begin
      angle = {8'd0, in_mant} >> (8'(F2Q_BIAS) - in_exp);
    end
    s0_d = '{flag: in_exp[7], x: K_Q30, y: '0, z: angle};
  end

  assign start_sr_d = {start_sr_q[LATENCY-2:0], start};

  // NOTE: reset is synchronous and overrides clk_en; state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (aclr) begin
      start_sr_q <= '0;
      s0_q       <= '0;
    end else if (clk_en) begin
      start_sr_q <= start_sr_d;
      s0_q       <= s0_d;
    end
  end

  assign pipe[0] = s0_q;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    cordic_stage4 #(
      .STAGE_IDX (s + 1)
    ) u_stage (
      .clock  (clock),
      .aclr   (aclr),
      .clk_en (clk_en),
      .vec_i  (pipe[s]),
      .vec_o  (pipe[s+1])
    );
  end

  assign out_x    = pipe[NUM_STAGES].x;
  assign out_lead = lead_one(out_x);

  // Normalise so the leading one lands at bit 31; the 23 bits below it are the mantissa.
  always_comb begin
    result = '0;
    if (pipe[NUM_STAGES].flag) begin
      result = NAN_F32;
    end else if (!out_x[31] && out_x != '0) begin
      result = {1'b0,
                8'(Q2F_BIAS) + {3'b000, out_lead},
                23'((out_x << (5'd31 - out_lead)) >> 8)};
    end
  end

  assign done = start_sr_q[LATENCY-1];

  assign unused_bits = ^{dataa[31], pipe[NUM_STAGES].y, pipe[NUM_STAGES].z};

endmodule

// File: tb/tb_cordic_unroll4_var.sv
// Self-checking bench for cordic_unroll4_var: directed vector table, multi-cycle
// corner sequences, and a randomized stream scored against a behavioural CORDIC model.
module tb_cordic_unroll4_var;

  localparam logic [31:0] NAN_BITS = 32'h7FC0_0000;
  localparam logic [31:0] K_BITS   = 32'h26DD_3B6A;
  // 16 micro-rotations leave a residual angle of up to atan(2^-15), so allow 2^-14.
  localparam real         TOL      = 1.0 / 16384.0;

  logic        clock  = 1'b0;
  logic        aclr   = 1'b1;
  logic        clk_en = 1'b0;
  logic        start  = 1'b0;
  logic [31:0] dataa  = '0;
  logic [31:0] result;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  int atan_tab [16];

  typedef struct {
    logic [31:0] dataa;
    logic        is_nan;
    real         cos_ref;
  } vec_t;

  typedef struct {
    logic        v;
    logic [31:0] r;
  } exp_t;

  vec_t vecs [12];
  exp_t sb [$];

  always #5 clock = ~clock;

  cordic_unroll4_var #(
    .ITERATIONS (16),
    .LATENCY    (5)
  ) dut (
    .clock  (clock),
    .aclr   (aclr),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .result (result),
    .done   (done)
  );

  function automatic real f2r(input logic [31:0] b);
    int  e;
    real v;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    for (int i = 127; i < e; i++) v = v * 2.0;
    for (int i = e; i < 127; i++) v = v / 2.0;
    return b[31] ? -v : v;
  endfunction

  // cos via the CORDIC recurrence on Q2.30 integers, returned as IEEE single (truncated).
  function automatic logic [31:0] model_cos(input logic [31:0] a);
    real mag;
    int  x, y, z, xn, p, m;
    if (a[30:23] >= 8'd128) return NAN_BITS;
    mag = f2r({1'b0, a[30:0]});
    z   = $rtoi(mag * 1073741824.0);
    x   = int'(K_BITS);
    y   = 0;
    for (int i = 0; i < 16; i++) begin
      if (z >= 0) begin
        xn = x - (y >>> i);
        y  = y + (x >>> i);
        z  = z - atan_tab[i];
      end else begin
        xn = x + (y >>> i);
        y  = y - (x >>> i);
        z  = z + atan_tab[i];
      end
      x = xn;
    end
    if (x <= 0) return 32'h0;
    p = 0;
    while ((x >> (p + 1)) != 0) p++;
    m = (p >= 23) ? (x >> (p - 23)) : (x << (23 - p));
    return {1'b0, 8'(97 + p), m[22:0]};
  endfunction

  function automatic logic [31:0] rand_float();
    logic [7:0] e;
    case ($urandom_range(0, 15))
      0:       e = 8'd0;
      1:       e = 8'd255;
      default: e = 8'($urandom_range(90, 130));
    endcase
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input logic [31:0] act, input real ref_val);
    real got, diff;
    got  = f2r(act);
    diff = got - ref_val;
    if (diff < 0.0) diff = -diff;
    n_checks++;
    if (act[31] || diff > TOL) begin
      n_fail++;
      $display("FAIL %s: got %f (%08h) expected %f", name, got, act, ref_val);
    end
  endtask

  task automatic tick(input logic st, input logic [31:0] a, input logic en);
    start  = st;
    dataa  = a;
    clk_en = en;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] b2b_in  [3];
    real         b2b_ref [3];
    real         t;
    exp_t        e;
    logic        en, st;
    logic [31:0] a;

    t = 1.0;
    for (int i = 0; i < 16; i++) begin
      atan_tab[i] = $rtoi($atan(t) * 1073741824.0);
      t = t / 2.0;
    end

    vecs[0]  = '{32'h0000_0000, 1'b0, 1.0};
    vecs[1]  = '{32'h3F80_0000, 1'b0, 0.5403023};
    vecs[2]  = '{32'hBF80_0000, 1'b0, 0.5403023};
    vecs[3]  = '{32'h3F00_0000, 1'b0, 0.8775826};
    vecs[4]  = '{32'hBE80_0000, 1'b0, 0.9689124};
    vecs[5]  = '{32'h3FC0_0000, 1'b0, 0.0707372};
    vecs[6]  = '{32'h0000_0001, 1'b0, 1.0};
    vecs[7]  = '{32'h3000_0000, 1'b0, 1.0};
    vecs[8]  = '{32'h3FFF_FFFF, 1'b0, 0.0};
    vecs[9]  = '{32'h4000_0000, 1'b1, 0.0};
    vecs[10] = '{32'h7F80_0000, 1'b1, 0.0};
    vecs[11] = '{32'hFFC0_0000, 1'b1, 0.0};

    // Reset state
    aclr = 1'b1;
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b1);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'h0);
    aclr = 1'b0;

    // Directed vectors, one at a time: done exactly on the fifth enabled edge
    foreach (vecs[i]) begin
      tick(1'b1, vecs[i].dataa, 1'b1);
      check($sformatf("vec%0d_busy1", i), {31'd0, done}, 32'd0);
      for (int k = 2; k <= 4; k++) begin
        tick(1'b0, $urandom, 1'b1);
        check($sformatf("vec%0d_busy%0d", i, k), {31'd0, done}, 32'd0);
      end
      tick(1'b0, $urandom, 1'b1);
      check($sformatf("vec%0d_done", i), {31'd0, done}, 32'd1);
      check($sformatf("vec%0d_model", i), result, model_cos(vecs[i].dataa));
      if (vecs[i].is_nan) check($sformatf("vec%0d_nan", i), result, NAN_BITS);
      else                check_near($sformatf("vec%0d_cos", i), result, vecs[i].cos_ref);
    end

    // Back-to-back starts, results on consecutive done cycles
    b2b_in  = '{32'h3F00_0000, 32'hBE80_0000, 32'h3FC0_0000};
    b2b_ref = '{0.8775826, 0.9689124, 0.0707372};
    for (int j = 0; j < 3; j++) tick(1'b1, b2b_in[j], 1'b1);
    tick(1'b0, '0, 1'b1);
    check("b2b_wait", {31'd0, done}, 32'd0);
    for (int j = 0; j < 3; j++) begin
      tick(1'b0, '0, 1'b1);
      check($sformatf("b2b%0d_done", j), {31'd0, done}, 32'd1);
      check($sformatf("b2b%0d_model", j), result, model_cos(b2b_in[j]));
      check_near($sformatf("b2b%0d_cos", j), result, b2b_ref[j]);
    end
    tick(1'b0, '0, 1'b1);
    check("b2b_end", {31'd0, done}, 32'd0);

    // Stall mid-flight: 3 disabled edges stretch latency to 8 edges
    tick(1'b1, 32'h3F80_0000, 1'b1);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick(1'(k % 2 == 0), $urandom, 1'b0);
      check($sformatf("stall%0d_done", k), {31'd0, done}, 32'd0);
    end
    tick(1'b0, '0, 1'b1);
    check("stall_e7_done", {31'd0, done}, 32'd0);
    tick(1'b0, '0, 1'b1);
    check("stall_e8_done", {31'd0, done}, 32'd1);
    check("stall_e8_result", result, model_cos(32'h3F80_0000));
    for (int k = 0; k < 3; k++) begin
      tick(1'(k % 2 == 0), $urandom, 1'b0);
      check($sformatf("hold%0d_done", k), {31'd0, done}, 32'd1);
      check($sformatf("hold%0d_result", k), result, model_cos(32'h3F80_0000));
    end
    tick(1'b0, '0, 1'b1);
    check("hold_release", {31'd0, done}, 32'd0);

    // Reset at edge 2 drops the in-flight operation
    tick(1'b1, 32'h3F80_0000, 1'b1);
    aclr = 1'b1;
    tick(1'b0, '0, 1'b1);
    aclr = 1'b0;
    check("midrst_result", result, 32'h0);
    for (int k = 0; k < 8; k++) begin
      tick(1'b0, '0, 1'b1);
      check($sformatf("midrst%0d_done", k), {31'd0, done}, 32'd0);
    end

    // Reset wins over clk_en=0 with a full pipeline
    for (int k = 0; k < 5; k++) tick(1'b1, 32'h3F00_0000, 1'b1);
    aclr = 1'b1;
    tick(1'b1, '0, 1'b0);
    aclr = 1'b0;
    check("rst_noen_done", {31'd0, done}, 32'd0);
    check("rst_noen_result", result, 32'h0);

    // First start after reset: done exactly 5 enabled edges later
    tick(1'b1, 32'h3F00_0000, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("postrst_busy%0d", k), {31'd0, done}, 32'd0);
      tick(1'b0, '0, 1'b1);
    end
    check("postrst_done", {31'd0, done}, 32'd1);
    check("postrst_result", result, model_cos(32'h3F00_0000));

    // Randomized stream with random clk_en, scored by enabled-edge delay queue
    aclr = 1'b1;
    tick(1'b0, '0, 1'b1);
    aclr = 1'b0;
    sb.delete();
    for (int c = 0; c < 800; c++) begin
      en = ($urandom_range(0, 3) != 0);
      st = 1'($urandom_range(0, 1));
      a  = rand_float();
      tick(st, a, en);
      if (en) begin
        sb.push_back('{st, model_cos(a)});
        if (sb.size() > 5) void'(sb.pop_front());
      end
      e = (sb.size() == 5) ? sb[0] : '{1'b0, 32'h0};
      check($sformatf("rnd%0d_done", c), {31'd0, done}, {31'd0, e.v});
      if (e.v) check($sformatf("rnd%0d_result", c), result, e.r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
